nes_attr_fetch: RTL and testbench
=================================

# nes_attr_fetch

Attribute-fetch stage that sits directly downstream of the combinational attribute-table ROM (128 × 8, 64 entries used, 8 × 8 attribute grid). Once per scanline it prefetches the 8 attribute bytes covering the upcoming 32-pixel row band into a line buffer, during horizontal blank. It then supplies a registered 2-bit palette select for every visible pixel to the background pixel pipeline.

## Interface
- No parameters. Fixed geometry: 256×240 pixels, 8 attribute columns × 8 attribute rows.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse in hblank before line `row` is displayed
- row  in  8  pixel row (0–239) of the upcoming line; sampled on line_start
- attr_addr  out  7  address to the attribute ROM
- attr_data  in  8  ROM data, valid in the same cycle as attr_addr
- col  in  8  pixel column (0–255) of the current pixel
- pix_valid  in  1  current pixel is visible and needs a palette select
- pal  out  2  palette select for the pixel presented one cycle earlier
- pal_valid  out  1  pal is valid
- busy  out  1  line buffer load in progress
- ready  out  1  line buffer holds the band of the current line
- underrun  out  1  sticky: pix_valid arrived while ready=0

## Operation
- State machine: IDLE → LOAD → READY.
  - Reset enters IDLE with the buffer marked invalid.
  - READY persists until the next miss.
- On line_start:
  - Latch band = row[7:5] and vhalf = row[4].
  - Hit (buffer valid and band equals the loaded band): remain in or enter READY. No ROM access.
  - Miss: enter LOAD, clear ready, and reset the 3-bit index i to 0.
- LOAD:
  - attr_addr = {1'b0, band, i}. Store attr_data into buf[i]. Increment i.
  - After i=7 is stored: loaded band = band, buffer valid, go to READY.
- attr_addr = 0 whenever not in LOAD.
- line_start during LOAD restarts the load with the newly latched band. The partial contents are discarded.
- Rows 224–239 map to band 7, the half-height bottom row. No special case.
- Quadrant select:
  - shift = 2·{vhalf, col[4]}.
  - Bits [1:0] = top-left, [3:2] = top-right, [5:4] = bottom-left, [7:6] = bottom-right.
  - Selected byte = buf[col[7:5]].
- Pixel path:
  - If pix_valid and ready: pal ← (byte >> shift) & 2'b11 and pal_valid ← 1.
  - If pix_valid and not ready: pal ← 0, pal_valid ← 0, underrun ← 1.
  - If pix_valid=0: pal ← 0, pal_valid ← 0.
- underrun clears only on rst.

## Timing
- Reset values: attr_addr=0, pal=0, pal_valid=0, busy=0, ready=0, underrun=0. State IDLE, buffer invalid.
- Miss sequence, with line_start sampled high in cycle t:
  - busy=1 and ready=0 in cycles t+1 … t+8.
  - attr_addr = base+0 … base+7 in those cycles, one address per cycle.
  - ready=1 and busy=0 from cycle t+9.
- Hit: ready stays 1 without interruption. vhalf updates in cycle t+1.
- Pixel latency: 1 cycle. col/pix_valid at cycle n produce pal/pal_valid at n+1.
- A pixel in the same cycle as line_start uses the pre-update vhalf and buffer.
- rst mid-LOAD: everything returns to reset values on the next edge. The next line_start is always a miss.
- Hblank must provide at least 9 cycles between line_start and the first pix_valid on a miss.

## Test plan
- Reset, then line_start with row=0; pixels col=0,16 on line 0 and col=0,16 on row=16 (ROM byte 0 = 0x15) → busy for 8 cycles on addr 0…7, then pal = 01, 01, 01, 00.
- line_start with row=32, col=32 then col=48 on row=48 (bytes 0x11, 0x40 at addr 8, 9) → row 32 col 32 pal=00; row 48 col 48 pal=01.
- Consecutive lines with row=1 and row=2 after row=0 is loaded → no LOAD, busy stays 0, ready stays 1, attr_addr stays 0.
- Assert pix_valid 3 cycles after a miss line_start → pal_valid=0, pal=0, underrun=1 and stays 1 afterwards.
- line_start row=64 then line_start row=96 four cycles later → load restarts. The final buffer holds addr 24…31 (0x11, 0x44, 0x55, 0x55, 0x55, 0x05, 0x01, 0x44). ready rises 9 cycles after the second pulse.
- Assert rst in the 5th LOAD cycle → all outputs reach reset values the next cycle. A following line_start row=0 performs a full 8-address load.

Source files
------------

// File: rtl/nes_attr_fetch.sv
// Attribute-fetch stage: prefetches the 8 attribute bytes of a 32-pixel row band during hblank
// and supplies a registered 2-bit palette select for every visible pixel.
module nes_attr_fetch (
   input  logic       clk,
   input  logic       rst,
   input  logic       line_start,
   input  logic [7:0] row,
   output logic [6:0] attr_addr,
   input  logic [7:0] attr_data,
   input  logic [7:0] col,
   input  logic       pix_valid,
   output logic [1:0] pal,
   output logic       pal_valid,
   output logic       busy,
   output logic       ready,
   output logic       underrun
);

   typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

   state_e      state_q, state_d;
   logic [2:0]  band_q, band_d;
   logic        vhalf_q, vhalf_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  loaded_band_q, loaded_band_d;
   logic        buf_valid_q, buf_valid_d;
   logic [7:0]  line_buf_q [8];
   logic [7:0]  line_buf_d [8];
   logic [6:0]  addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic [1:0]  pal_q, pal_d;
   logic        pal_valid_q, pal_valid_d;
   logic        underrun_q, underrun_d;

   logic [2:0]  idx_next;
   logic [2:0]  shift;
   logic [7:0]  shifted;
   logic        hit;

   // Only the band/half and quadrant bits of row and col select anything.
   logic        unused_bits;
   assign unused_bits = ^{row[3:0], col[3:0]};

   assign idx_next = idx_q + 3'd1;
   assign hit      = buf_valid_q && (row[7:5] == loaded_band_q);

   // Quadrant select uses the pre-update half and buffer when a pixel coincides with line_start.
   assign shift    = {vhalf_q, col[4], 1'b0};
   assign shifted  = line_buf_q[col[7:5]] >> shift;

   always_comb begin
      state_d       = state_q;
      band_d        = band_q;
      vhalf_d       = vhalf_q;
      idx_d         = idx_q;
      loaded_band_d = loaded_band_q;
      buf_valid_d   = buf_valid_q;
      line_buf_d    = line_buf_q;
      addr_d        = addr_q;
      busy_d        = busy_q;
      ready_d       = ready_q;

      case (state_q)
         StLoad: begin
            line_buf_d[idx_q] = attr_data;
            idx_d             = idx_next;
            addr_d            = {1'b0, band_q, idx_next};
            if (idx_q == 3'd7) begin
               loaded_band_d = band_q;
               buf_valid_d   = 1'b1;
               state_d       = StReady;
               busy_d        = 1'b0;
               ready_d       = 1'b1;
               addr_d        = 7'd0;
            end
         end
         default: ;
      endcase

      // A new line always wins over a load in progress; partial contents are abandoned.
      if (line_start) begin
         band_d  = row[7:5];
         vhalf_d = row[4];
         if (hit) begin
            state_d = StReady;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            addr_d  = 7'd0;
         end else begin
            state_d     = StLoad;
            idx_d       = 3'd0;
            busy_d      = 1'b1;
            ready_d     = 1'b0;
            buf_valid_d = 1'b0;
            addr_d      = {1'b0, row[7:5], 3'd0};
         end
      end
   end

   always_comb begin
      pal_d       = 2'b00;
      pal_valid_d = 1'b0;
      underrun_d  = underrun_q;
      if (pix_valid) begin
         if (ready_q) begin
            pal_d       = shifted[1:0];
            pal_valid_d = 1'b1;
         end else begin
            underrun_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         band_q        <= 3'd0;
         vhalf_q       <= 1'b0;
         idx_q         <= 3'd0;
         loaded_band_q <= 3'd0;
         buf_valid_q   <= 1'b0;
         addr_q        <= 7'd0;
         busy_q        <= 1'b0;
         ready_q       <= 1'b0;
         pal_q         <= 2'b00;
         pal_valid_q   <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         band_q        <= band_d;
         vhalf_q       <= vhalf_d;
         idx_q         <= idx_d;
         loaded_band_q <= loaded_band_d;
         buf_valid_q   <= buf_valid_d;
         line_buf_q    <= line_buf_d;
         addr_q        <= addr_d;
         busy_q        <= busy_d;
         ready_q       <= ready_d;
         pal_q         <= pal_d;
         pal_valid_q   <= pal_valid_d;
         underrun_q    <= underrun_d;
      end
   end

   assign attr_addr = addr_q;
   assign busy      = busy_q;
   assign ready     = ready_q;
   assign pal       = pal_q;
   assign pal_valid = pal_valid_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_nes_attr_fetch.sv
// Randomized scoreboard bench for nes_attr_fetch against a behavioural line-buffer model.
module tb_nes_attr_fetch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_start = 1'b0;
   logic [7:0] row = 8'd0;
   logic [6:0] attr_addr;
   logic [7:0] attr_data;
   logic [7:0] col = 8'd0;
   logic       pix_valid = 1'b0;
   logic [1:0] pal;
   logic       pal_valid, busy, ready, underrun;

   logic [7:0] rom [128];
   assign attr_data = rom[attr_addr];

   always #5 clk = ~clk;

   nes_attr_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .line_start(line_start),
      .row       (row),
      .attr_addr (attr_addr),
      .attr_data (attr_data),
      .col       (col),
      .pix_valid (pix_valid),
      .pal       (pal),
      .pal_valid (pal_valid),
      .busy      (busy),
      .ready     (ready),
      .underrun  (underrun)
   );

   int checks = 0;
   int failures = 0;

   // Expected pixel responses: {underrun, pal_valid, pal[1:0]}
   logic [3:0] exp_q [$];
   logic       pix_prev = 1'b0;
   bit         mon_en = 1'b0;

   // Model: which band the line buffer holds and what the pixel path should see.
   logic [7:0] m_buf [8];
   logic [2:0] m_band;
   bit         m_valid, m_ready, m_under, m_vhalf;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) pix_prev <= pix_valid;

   always @(negedge clk) begin : monitor
      logic [3:0] e;
      if (mon_en) begin
         if (pix_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pix_unexpected: got pixel response with empty scoreboard at %0t",
                        $time);
            end else begin
               e = exp_q.pop_front();
               chk("pal", {6'd0, pal}, {6'd0, e[1:0]});
               chk("pal_valid", {7'd0, pal_valid}, {7'd0, e[2]});
               chk("underrun", {7'd0, underrun}, {7'd0, e[3]});
            end
         end else begin
            chk("pal_idle", {5'd0, pal_valid, pal}, 8'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_ready = 0;
      m_under = 0;
      m_vhalf = 0;
      m_band  = 3'd0;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs();
      chk("rst_addr", {1'b0, attr_addr}, 8'd0);
      chk("rst_pal", {6'd0, pal}, 8'd0);
      chk("rst_pal_valid", {7'd0, pal_valid}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_ready", {7'd0, ready}, 8'd0);
      chk("rst_underrun", {7'd0, underrun}, 8'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      line_start = 1'b0;
      pix_valid = 1'b0;
      tick();
      rst = 1'b0;
      model_reset();
      check_reset_outputs();
      mon_en = 1'b1;
   endtask

   // Drives one pixel for the coming cycle and records the expected response.
   task automatic push_pix(input logic [7:0] pc);
      logic [7:0] b;
      int q;
      if (m_ready) begin
         b = m_buf[pc / 32];
         q = (m_vhalf ? 2 : 0) + ((pc / 16) % 2);
         exp_q.push_back({m_under, 1'b1, 2'((b >> (2 * q)) & 8'd3)});
      end else begin
         m_under = 1;
         exp_q.push_back(4'b1000);
      end
      pix_valid = 1'b1;
      col = pc;
   endtask

   task automatic pixel(input logic [7:0] pc);
      push_pix(pc);
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic start_pulse(input logic [7:0] r, input bit wp, input logic [7:0] pc,
                              output bit miss);
      if (wp) push_pix(pc);
      miss = !(m_valid && (r / 32) == m_band);
      line_start = 1'b1;
      row = r;
      tick();
      line_start = 1'b0;
      pix_valid = 1'b0;
      m_vhalf = ((r / 16) % 2) == 1;
      if (miss) begin
         m_valid = 0;
         m_ready = 0;
         m_band  = 3'(r / 32);
      end
   endtask

   task automatic model_loaded();
      for (int k = 0; k < 8; k++) m_buf[k] = rom[m_band * 8 + k];
      m_valid = 1;
      m_ready = 1;
   endtask

   // Called in the first cycle after a missing line_start.
   task automatic check_load();
      for (int k = 0; k < 8; k++) begin
         chk("load_busy", {7'd0, busy}, 8'd1);
         chk("load_ready", {7'd0, ready}, 8'd0);
         chk("load_addr", {1'b0, attr_addr}, 8'(m_band * 8 + k));
         tick();
      end
      chk("done_busy", {7'd0, busy}, 8'd0);
      chk("done_ready", {7'd0, ready}, 8'd1);
      chk("done_addr", {1'b0, attr_addr}, 8'd0);
      model_loaded();
   endtask

   task automatic line(input logic [7:0] r, input bit wp, input logic [7:0] pc);
      bit miss;
      start_pulse(r, wp, pc, miss);
      if (miss) begin
         check_load();
      end else begin
         chk("hit_busy", {7'd0, busy}, 8'd0);
         chk("hit_ready", {7'd0, ready}, 8'd1);
         chk("hit_addr", {1'b0, attr_addr}, 8'd0);
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin : stimulus
      bit miss;
      int n;
      logic [7:0] r, pc;
      logic [7:0] fixed_hi [8];

      for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
      rom[0] = 8'h15;
      rom[8] = 8'h11;
      rom[9] = 8'h40;
      fixed_hi = '{8'h11, 8'h44, 8'h55, 8'h55, 8'h55, 8'h05, 8'h01, 8'h44};
      for (int i = 0; i < 8; i++) rom[24 + i] = fixed_hi[i];

      tick();
      do_reset();

      // Band 0, all four quadrants of byte 0x15.
      line(8'd0, 0, 8'd0);
      pixel(8'd0);
      pixel(8'd16);
      line(8'd16, 0, 8'd0);
      pixel(8'd0);
      pixel(8'd16);

      // Hits within the loaded band.
      line(8'd1, 0, 8'd0);
      line(8'd2, 0, 8'd0);

      line(8'd32, 0, 8'd0);
      pixel(8'd32);
      line(8'd48, 0, 8'd0);
      pixel(8'd48);

      // Pixel 3 cycles after a missing line_start.
      start_pulse(8'd128, 0, 8'd0, miss);
      tick();
      tick();
      pixel(8'd0);
      n = 0;
      while (!ready && n < 20) begin
         tick();
         n++;
      end
      chk("underrun_load_ready", {7'd0, ready}, 8'd1);
      model_loaded();
      pixel(8'd200);
      chk("underrun_sticky", {7'd0, underrun}, 8'd1);

      // Load restarted four cycles in by a new band.
      start_pulse(8'd64, 0, 8'd0, miss);
      tick();
      tick();
      tick();
      line(8'd96, 0, 8'd0);
      for (int c = 0; c < 256; c += 16) pixel(8'(c));
      line(8'd112, 0, 8'd0);
      for (int c = 8; c < 256; c += 16) pixel(8'(c));

      // Random lines, including pixels coincident with line_start.
      for (int it = 0; it < 40; it++) begin
         r = 8'($urandom_range(0, 239));
         pc = 8'($urandom);
         line(r, $urandom_range(0, 3) == 0, pc);
         n = $urandom_range(1, 12);
         for (int p = 0; p < n; p++) begin
            if ($urandom_range(0, 3) == 0) tick();
            pixel(8'($urandom));
         end
      end

      // Reset during the 5th load cycle.
      start_pulse(8'd160, 0, 8'd0, miss);
      tick();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_reset_outputs();
      line(8'd0, 0, 8'd0);
      pixel(8'd0);
      pixel(8'd16);
      chk("post_rst_underrun", {7'd0, underrun}, 8'd0);

      tick();
      tick();
      chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
